// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle controller and its decoder.
// Pure declarations; no logic, no latency, no flow control.
// Holds the state enum, control-field encodings, opcodes and the funct3 ALU map.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR
  } ins_class_e;

  localparam logic [5:0] EXT_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_ITYPE = 6'b010000;
  localparam logic [5:0] EXT_STYPE = 6'b001000;
  localparam logic [5:0] EXT_BTYPE = 6'b000100;
  localparam logic [5:0] EXT_UTYPE = 6'b000010;
  localparam logic [5:0] EXT_JTYPE = 6'b000001;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  localparam logic [4:0] ALU_NOP  = 5'b00000;
  localparam logic [4:0] ALU_LUI  = 5'b00001;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_SLT  = 5'b01010;
  localparam logic [4:0] ALU_SLTU = 5'b01011;
  localparam logic [4:0] ALU_XOR  = 5'b01100;
  localparam logic [4:0] ALU_OR   = 5'b01101;
  localparam logic [4:0] ALU_AND  = 5'b01110;
  localparam logic [4:0] ALU_SLL  = 5'b01111;
  localparam logic [4:0] ALU_SRL  = 5'b10000;
  localparam logic [4:0] ALU_SRA  = 5'b10001;
  localparam logic [4:0] ALU_MUL  = 5'b10010;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // funct3 -> ALU op shared by R-type and I-type arithmetic
  function automatic logic [4:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/memory bundle: instruction fields, flags, handshake, control.
// Wires only; no latency. Memory backpressure is carried by mem_ready.
// master = controller side, slave = datapath side.
interface mc_ctrl_if;
  logic [6:0] Op;
  logic [6:0] Funct7;
  logic [2:0] Funct3;
  logic       Zero;
  logic       Lt;
  logic       Ltu;
  logic       mem_ready;
  logic       mem_req;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [5:0] EXTOp;
  logic [4:0] ALUOp;
  logic [2:0] NPCOp;
  logic       ALUSrc;
  logic [1:0] WDSel;
  logic       fault;
  logic [2:0] state;

  modport master (
    input  Op, Funct7, Funct3, Zero, Lt, Ltu, mem_ready,
    output mem_req, MemWrite, IRWrite, PCWrite, RegWrite,
    output EXTOp, ALUOp, NPCOp, ALUSrc, WDSel, fault, state
  );

  modport slave (
    output Op, Funct7, Funct3, Zero, Lt, Ltu, mem_ready,
    input  mem_req, MemWrite, IRWrite, PCWrite, RegWrite,
    input  EXTOp, ALUOp, NPCOp, ALUSrc, WDSel, fault, state
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction decode: legality, class, ALU/ext/src fields, branch outcome.
// Zero latency; no flow control. MC_CTRL_RV32M_EN adds the funct7=0000001 mul/div group.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       legal,
  output ins_class_e cls,
  output logic [4:0] alu_op,
  output logic       alu_src,
  output logic [5:0] ext_op,
  output logic       br_taken
);

  always_comb begin
    legal    = 1'b0;
    cls      = C_ALU;
    alu_op   = ALU_NOP;
    alu_src  = 1'b0;
    ext_op   = 6'd0;
    br_taken = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct7)
          F7_BASE: begin
            legal  = 1'b1;
            alu_op = base_alu(funct3);
          end
          F7_ALT: begin
            legal  = (funct3 == 3'b000) || (funct3 == 3'b101);
            alu_op = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
          end
`ifdef MC_CTRL_RV32M_EN
          F7_MULDIV: begin
            legal  = 1'b1;
            alu_op = ALU_MUL + {2'b00, funct3};
          end
`endif
          default: ;
        endcase
      end
      OP_IALU: begin
        legal   = 1'b1;
        alu_src = 1'b1;
        ext_op  = EXT_ITYPE;
        alu_op  = base_alu(funct3);
        // shifts reuse funct7 as the sub-opcode; other I-ops treat it as immediate
        if (funct3 == 3'b001) begin
          ext_op = EXT_SHAMT;
          legal  = (funct7 == F7_BASE);
        end else if (funct3 == 3'b101) begin
          ext_op = EXT_SHAMT;
          legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          if (funct7 == F7_ALT) alu_op = ALU_SRA;
        end
      end
      OP_LOAD: begin
        legal   = (funct3 == 3'b010);
        cls     = C_LOAD;
        alu_op  = ALU_ADD;
        alu_src = 1'b1;
        ext_op  = EXT_ITYPE;
      end
      OP_STORE: begin
        legal   = (funct3 == 3'b010);
        cls     = C_STORE;
        alu_op  = ALU_ADD;
        alu_src = 1'b1;
        ext_op  = EXT_STYPE;
      end
      OP_BRANCH: begin
        legal  = (funct3[2:1] != 2'b01);
        cls    = C_BRANCH;
        alu_op = ALU_SUB;
        ext_op = EXT_BTYPE;
        // funct3[0] inverts the selected compare flag
        case (funct3[2:1])
          2'b00:   br_taken = zero ^ funct3[0];
          2'b10:   br_taken = lt ^ funct3[0];
          2'b11:   br_taken = ltu ^ funct3[0];
          default: br_taken = 1'b0;
        endcase
      end
      OP_JAL: begin
        legal  = 1'b1;
        cls    = C_JAL;
        ext_op = EXT_JTYPE;
      end
      OP_JALR: begin
        legal  = (funct3 == 3'b000);
        cls    = C_JALR;
        ext_op = EXT_ITYPE;
      end
      OP_LUI: begin
        legal   = 1'b1;
        alu_op  = ALU_LUI;
        alu_src = 1'b1;
        ext_op  = EXT_UTYPE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/FAULT); MC_CTRL_RV32M_EN enables mul/div decode.
// Latency: 3 cycles after fetch (ALU), 2 (branch/jump), 3+ (load/store, memory-dependent).
// Backpressure: holds FETCH/MEM while mem_ready=0; faults after MEM_TIMEOUT wait cycles.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.master bus
);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  logic       dec_legal, dec_alu_src, dec_br_taken;
  ins_class_e dec_cls;
  logic [4:0] dec_alu_op;
  logic [5:0] dec_ext_op;

  logic       mem_req, mem_write, ir_write, pc_write, reg_write, alu_src, fault;
  logic [5:0] ext_op;
  logic [4:0] alu_op;
  logic [2:0] npc_op;
  logic [1:0] wd_sel;
  logic       timeout;

  mc_decode u_decode (
    .op       (bus.Op),
    .funct7   (bus.Funct7),
    .funct3   (bus.Funct3),
    .zero     (bus.Zero),
    .lt       (bus.Lt),
    .ltu      (bus.Ltu),
    .legal    (dec_legal),
    .cls      (dec_cls),
    .alu_op   (dec_alu_op),
    .alu_src  (dec_alu_src),
    .ext_op   (dec_ext_op),
    .br_taken (dec_br_taken)
  );

  // a ready arriving on the last allowed wait cycle still completes the access
  assign timeout = !bus.mem_ready && (wait_q == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    alu_src   = 1'b0;
    fault     = 1'b0;
    ext_op    = 6'd0;
    alu_op    = ALU_NOP;
    npc_op    = NPC_PLUS4;
    wd_sel    = WD_ALU;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: state_d = dec_legal ? S_EXEC : S_FAULT;
      S_EXEC: begin
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
        ext_op  = dec_ext_op;
        case (dec_cls)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH: begin
            pc_write = 1'b1;
            npc_op   = dec_br_taken ? NPC_BRANCH : NPC_PLUS4;
            state_d  = S_FETCH;
          end
          C_JAL, C_JALR: begin
            reg_write = 1'b1;
            wd_sel    = WD_PC;
            pc_write  = 1'b1;
            npc_op    = (dec_cls == C_JAL) ? NPC_JUMP : NPC_JALR;
            state_d   = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_write = (dec_cls == C_STORE);
        if (bus.mem_ready) begin
          if (dec_cls == C_STORE) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wd_sel    = (dec_cls == C_LOAD) ? WD_MEM : WD_ALU;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_FAULT;
    endcase

    if ((state_d != state_q) || bus.mem_ready) wait_d = 8'd0;
    else if (mem_req)                          wait_d = wait_q + 8'd1;
    else                                       wait_d = wait_q;
  end

  // reset silences every output in the cycle it is asserted, aborting any access
  assign bus.mem_req  = mem_req & ~rst;
  assign bus.MemWrite = mem_write & ~rst;
  assign bus.IRWrite  = ir_write & ~rst;
  assign bus.PCWrite  = pc_write & ~rst;
  assign bus.RegWrite = reg_write & ~rst;
  assign bus.ALUSrc   = alu_src & ~rst;
  assign bus.fault    = fault & ~rst;
  assign bus.EXTOp    = rst ? 6'd0 : ext_op;
  assign bus.ALUOp    = rst ? 5'd0 : alu_op;
  assign bus.NPCOp    = rst ? 3'd0 : npc_op;
  assign bus.WDSel    = rst ? 2'd0 : wd_sel;
  assign bus.state    = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: each instruction is expanded into an expected per-cycle trace from an
// instruction table, then replayed against the DUT. Honors MC_CTRL_RV32M_EN like the RTL.
module tb_mc_ctrl;
  localparam int T = 4;
  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_JAL = 4, K_JALR = 5;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111;
  localparam logic [6:0] OPS [9] = '{R, I, LD, ST, BR, JAL, JALR, LUI, 7'b0001011};
  localparam logic [4:0] F3ALU [8] = '{5'b00011, 5'b01111, 5'b01010, 5'b01011,
                                       5'b01100, 5'b10000, 5'b01101, 5'b01110};

  typedef struct packed {
    logic       mem_req, mem_write, ir_write, pc_write, reg_write;
    logic [5:0] ext;
    logic [4:0] alu;
    logic [2:0] npc;
    logic       src;
    logic [1:0] wd;
    logic       fault;
    logic [2:0] st;
  } out_t;

  typedef struct {
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic       dc7, dc3;
    int         kind;
    logic [4:0] alu;
    logic [5:0] ext;
    logic       src;
    int         brf;
    logic       brinv;
  } ent_t;

  typedef struct {
    logic       rst, rdy;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic       z, lt, ltu;
    out_t       ex;
  } cyc_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0, n_err = 0, cyc_no = 0;
  ent_t tbl[$];
  cyc_t q[$];
  cyc_t tpl;

  always #5 clk = ~clk;

  mc_ctrl_if bus();
  mc_ctrl #(.MEM_TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic add_ent(input logic [6:0] op, f7, input logic [2:0] f3, input logic dc7, dc3,
                         input int kind, input logic [4:0] alu, input logic [5:0] ext,
                         input logic src, input int brf, input logic brinv);
    ent_t e;
    e.op = op; e.f7 = f7; e.f3 = f3; e.dc7 = dc7; e.dc3 = dc3; e.kind = kind;
    e.alu = alu; e.ext = ext; e.src = src; e.brf = brf; e.brinv = brinv;
    tbl.push_back(e);
  endtask

  task automatic build_table();
    for (int f = 0; f < 8; f++) begin
      add_ent(R, 7'b0, 3'(f), 0, 0, K_ALU, F3ALU[f], 6'b0, 0, 0, 0);
      if (f != 1 && f != 5) add_ent(I, 7'b0, 3'(f), 1, 0, K_ALU, F3ALU[f], 6'b010000, 1, 0, 0);
`ifdef MC_CTRL_RV32M_EN
      add_ent(R, 7'b0000001, 3'(f), 0, 0, K_ALU, 5'(18 + f), 6'b0, 0, 0, 0);
`endif
    end
    add_ent(R, 7'b0100000, 3'd0, 0, 0, K_ALU, 5'b00100, 6'b0, 0, 0, 0);
    add_ent(R, 7'b0100000, 3'd5, 0, 0, K_ALU, 5'b10001, 6'b0, 0, 0, 0);
    add_ent(I, 7'b0000000, 3'd1, 0, 0, K_ALU, 5'b01111, 6'b100000, 1, 0, 0);
    add_ent(I, 7'b0000000, 3'd5, 0, 0, K_ALU, 5'b10000, 6'b100000, 1, 0, 0);
    add_ent(I, 7'b0100000, 3'd5, 0, 0, K_ALU, 5'b10001, 6'b100000, 1, 0, 0);
    add_ent(LD, 7'b0, 3'd2, 1, 0, K_LD, 5'b00011, 6'b010000, 1, 0, 0);
    add_ent(ST, 7'b0, 3'd2, 1, 0, K_ST, 5'b00011, 6'b001000, 1, 0, 0);
    add_ent(BR, 7'b0, 3'd0, 1, 0, K_BR, 5'b00100, 6'b000100, 0, 0, 0);
    add_ent(BR, 7'b0, 3'd1, 1, 0, K_BR, 5'b00100, 6'b000100, 0, 0, 1);
    add_ent(BR, 7'b0, 3'd4, 1, 0, K_BR, 5'b00100, 6'b000100, 0, 1, 0);
    add_ent(BR, 7'b0, 3'd5, 1, 0, K_BR, 5'b00100, 6'b000100, 0, 1, 1);
    add_ent(BR, 7'b0, 3'd6, 1, 0, K_BR, 5'b00100, 6'b000100, 0, 2, 0);
    add_ent(BR, 7'b0, 3'd7, 1, 0, K_BR, 5'b00100, 6'b000100, 0, 2, 1);
    add_ent(JAL, 7'b0, 3'd0, 1, 1, K_JAL, 5'b0, 6'b000001, 0, 0, 0);
    add_ent(JALR, 7'b0, 3'd0, 1, 0, K_JALR, 5'b0, 6'b010000, 0, 0, 0);
    add_ent(LUI, 7'b0, 3'd0, 1, 1, K_ALU, 5'b00001, 6'b000010, 1, 0, 0);
  endtask

  function automatic int find(input logic [6:0] op, f7, input logic [2:0] f3);
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].op == op && (tbl[i].dc7 || tbl[i].f7 == f7) && (tbl[i].dc3 || tbl[i].f3 == f3))
        return i;
    return -1;
  endfunction

  function automatic out_t o(input logic [2:0] st);
    out_t x;
    x = '0;
    x.st = st;
    return x;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1));
  endfunction

  task automatic push(input logic r, input logic rdy, input out_t e);
    cyc_t c;
    c = tpl;
    c.rst = r; c.rdy = rdy; c.ex = e;
    q.push_back(c);
  endtask

  task automatic fault_tail();
    out_t x;
    x = o(3'd5);
    x.fault = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b0, rb(), x);
    push(1'b1, rb(), '0);
  endtask

  // Expected trace of one instruction: wf/wm = not-ready cycles in fetch/memory (>=T times out),
  // ab = memory wait cycle on which reset is asserted (-1 for none).
  task automatic build(input logic [6:0] op, f7, input logic [2:0] f3, input logic z, lt, ltu,
                       input int wf, wm, ab);
    int   idx;
    ent_t e;
    out_t x;
    logic flag;
    tpl.op = op; tpl.f7 = f7; tpl.f3 = f3; tpl.z = z; tpl.lt = lt; tpl.ltu = ltu;
    for (int i = 0; i < wf && i < T; i++) begin
      x = o(3'd0); x.mem_req = 1'b1; push(1'b0, 1'b0, x);
    end
    if (wf >= T) begin fault_tail(); return; end
    x = o(3'd0); x.mem_req = 1'b1; x.ir_write = 1'b1; push(1'b0, 1'b1, x);
    push(1'b0, rb(), o(3'd1));
    idx = find(op, f7, f3);
    if (idx < 0) begin fault_tail(); return; end
    e = tbl[idx];
    x = o(3'd2); x.alu = e.alu; x.ext = e.ext; x.src = e.src;
    if (e.kind == K_BR) begin
      flag = (e.brf == 0) ? z : (e.brf == 1) ? lt : ltu;
      x.pc_write = 1'b1;
      x.npc = (flag ^ e.brinv) ? 3'b001 : 3'b000;
      push(1'b0, rb(), x);
      return;
    end
    if (e.kind == K_JAL || e.kind == K_JALR) begin
      x.reg_write = 1'b1; x.wd = 2'b10; x.pc_write = 1'b1;
      x.npc = (e.kind == K_JAL) ? 3'b010 : 3'b100;
      push(1'b0, rb(), x);
      return;
    end
    push(1'b0, rb(), x);
    if (e.kind == K_LD || e.kind == K_ST) begin
      for (int i = 0; i < wm && i < T; i++) begin
        if (i == ab) begin push(1'b1, 1'b0, '0); return; end
        x = o(3'd3); x.mem_req = 1'b1; x.mem_write = (e.kind == K_ST); push(1'b0, 1'b0, x);
      end
      if (wm >= T) begin fault_tail(); return; end
      x = o(3'd3); x.mem_req = 1'b1; x.mem_write = (e.kind == K_ST);
      if (e.kind == K_ST) begin
        x.pc_write = 1'b1;
        push(1'b0, 1'b1, x);
        return;
      end
      push(1'b0, 1'b1, x);
    end
    x = o(3'd4); x.reg_write = 1'b1; x.pc_write = 1'b1;
    x.wd = (e.kind == K_LD) ? 2'b01 : 2'b00;
    push(1'b0, rb(), x);
  endtask

  task automatic run_q();
    cyc_t c;
    out_t g;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(posedge clk);
      #1;
      rst = c.rst; bus.mem_ready = c.rdy;
      bus.Op = c.op; bus.Funct7 = c.f7; bus.Funct3 = c.f3;
      bus.Zero = c.z; bus.Lt = c.lt; bus.Ltu = c.ltu;
      @(negedge clk);
      g.mem_req = bus.mem_req; g.mem_write = bus.MemWrite; g.ir_write = bus.IRWrite;
      g.pc_write = bus.PCWrite; g.reg_write = bus.RegWrite; g.ext = bus.EXTOp;
      g.alu = bus.ALUOp; g.npc = bus.NPCOp; g.src = bus.ALUSrc; g.wd = bus.WDSel;
      g.fault = bus.fault; g.st = bus.state;
      chk($sformatf("cyc%0d st%0d", cyc_no, c.ex.st), 32'(g), 32'(c.ex));
      cyc_no++;
    end
  endtask

  initial begin
    logic [6:0] op, f7;
    logic [2:0] f3;
    ent_t       e;
    int         wf, wm, ab;
    rst = 1'b1;
    bus.mem_ready = 1'b0; bus.Op = '0; bus.Funct7 = '0; bus.Funct3 = '0;
    bus.Zero = 1'b0; bus.Lt = 1'b0; bus.Ltu = 1'b0;
    build_table();
    tpl.op = '0; tpl.f7 = '0; tpl.f3 = '0; tpl.z = 1'b0; tpl.lt = 1'b0; tpl.ltu = 1'b0;
    push(1'b1, 1'b0, '0);
    push(1'b1, 1'b0, '0);

    build(R, 7'b0, 3'd0, 0, 0, 0, 0, 0, -1);           // add, memory always ready
    build(LD, 7'h15, 3'd2, 0, 0, 0, 1, 3, -1);         // lw, ready 3 cycles late in MEM
    build(BR, 7'b0, 3'd5, 0, 0, 0, 0, 0, -1);          // bge taken
    build(BR, 7'b0, 3'd5, 0, 1, 0, 0, 0, -1);          // bge not taken
    build(I, 7'h3f, 3'd0, 0, 0, 0, T - 1, 0, -1);      // ready on last allowed wait
    build(R, 7'b0, 3'd0, 0, 0, 0, T, 0, -1);           // fetch timeout
    build(7'b0001011, 7'b0, 3'd0, 0, 0, 0, 0, 0, -1);  // unsupported opcode
    build(R, 7'b0000001, 3'd0, 0, 0, 0, 0, 0, -1);     // mul
    build(ST, 7'b0, 3'd2, 0, 0, 0, 0, 3, 1);           // reset during sw wait
    build(ST, 7'b0, 3'd2, 0, 0, 0, 0, T, -1);          // memory timeout
    build(JALR, 7'b0, 3'd0, 0, 0, 0, 0, 1, -1);
    run_q();

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(9) < 7) begin
        e  = tbl[$urandom_range(tbl.size() - 1)];
        op = e.op;
        f7 = e.dc7 ? 7'($urandom) : e.f7;
        f3 = e.dc3 ? 3'($urandom) : e.f3;
      end else begin
        op = ($urandom_range(7) == 0) ? 7'($urandom) : OPS[$urandom_range(8)];
        f7 = ($urandom_range(1) == 0) ? 7'($urandom) : 7'($urandom_range(1) << 5);
        f3 = 3'($urandom);
      end
      wf = ($urandom_range(11) == 0) ? T : $urandom_range(T - 1);
      wm = ($urandom_range(11) == 0) ? T : $urandom_range(T - 1);
      ab = ($urandom_range(5) == 0) ? $urandom_range(T - 1) : -1;
      build(op, f7, f3, rb(), rb(), rb(), wf, wm, ab);
      run_q();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
